maxpool2x2_stream: RTL and testbench
====================================

# maxpool2x2_stream

Streaming 2×2, stride-2 max-pooling stage for VGG16 feature maps. It sits directly downstream of the convolution bias-add/ReLU stage and consumes its `o_data`/`valid_out` pixel stream in raster order, one channel plane at a time. It emits one IEEE-754 single-precision maximum per 2×2 window. A half-width line buffer holds the upper-row partial maxima.

## Interface
- `DATA_WIDTH`, 32: pixel width, IEEE-754 single precision.
- `IMG_WIDTH`, 224: input plane width in pixels. Must be even and ≥ 2.
- `IMG_HEIGHT`, 224: input plane height in pixels. Must be even and ≥ 2.
- `clk`  input  1  clock. All state updates on the rising edge.
- `rst`  input  1  asynchronous, active-low reset (asserted when 0).
- `i_data`  input  DATA_WIDTH  input pixel, valid when `valid_in`=1.
- `valid_in`  input  1  input qualifier. No backpressure; every valid pixel is consumed.
- `o_data`  output  DATA_WIDTH  pooled pixel (register).
- `valid_out`  output  1  one-cycle pulse per pooled pixel (register).
- `frame_done`  output  1  pulses together with the last pooled pixel of a plane (register).

## Operation
- Counters `col` (0..IMG_WIDTH-1) and `row` (0..IMG_HEIGHT-1) advance only on cycles with `valid_in`=1. Gaps in `valid_in` of any length freeze all state.
- `col` wraps to 0 and increments `row`. `row` wraps to 0 at the end of the plane, so the next plane follows back-to-back with no idle cycle.
- Even `col`: capture `i_data` into `hold`.
- Odd `col`, even `row`: `linebuf[col>>1]` ← fpmax(`hold`, `i_data`). No output.
- Odd `col`, odd `row`: `o_data` ← fpmax(fpmax(`hold`, `i_data`), `linebuf[col>>1]`), and `valid_out` ← 1.
  - If `row`=IMG_HEIGHT-1 and `col`=IMG_WIDTH-1, `frame_done` ← 1 as well.
- In every other cycle, `valid_out` and `frame_done` ← 0 and `o_data` holds its last value.
- fpmax compares values in sign-magnitude order:
  - Both positive: the larger magnitude wins.
  - Both negative: the smaller magnitude wins.
  - Positive beats negative.
  - −0 and +0 compare equal.
  - On a tie, the first operand is returned (bit-exact), so the result is always one of the inputs.
- NaN and Inf inputs are not expected. Behaviour for them is the sign-magnitude ordering above, with no special-casing.
- Negative inputs must be handled correctly even though upstream ReLU normally prevents them.
- Output count per plane is (IMG_WIDTH/2)·(IMG_HEIGHT/2).

## Timing
- Reset (`rst`=0) values: `o_data`=0, `valid_out`=0, `frame_done`=0, `col`=0, `row`=0, `hold`=0.
- `linebuf` is not reset. Row 0 of every plane overwrites it before it is read.
- Latency: `valid_out` rises on the edge after the cycle that presents the bottom-right pixel of a window with `valid_in`=1 (1 cycle).
- Throughput: one input per cycle sustained. There is at most one output per 2 input cycles within odd rows.
- `linebuf` is written on even rows and read on odd rows. It is never read and written at the same address in the same cycle.
- Reset mid-plane: outputs clear immediately (asynchronously). After release, the next valid pixel is treated as (row 0, col 0). A partial window in progress is discarded.
- Reset is released synchronously to `clk` by the surrounding logic.

## Structure
- The shared package holds:
  - FP32 field constants: sign bit 31, exponent [30:23], mantissa [22:0].
  - The address-width helper `LB_AW = $clog2(IMG_WIDTH/2)`.
- Sub-module `fp_max` is combinational, with ports `a`, `b` → `y` (tie returns `a`). It is instantiated twice: `hold`/`i_data`, then result/`linebuf`.
- `linebuf` is a register array or distributed RAM of IMG_WIDTH/2 × DATA_WIDTH with one write port and one asynchronous read port.

## Test plan
- **4×4 plane, basic max.** IMG_WIDTH=IMG_HEIGHT=4. Input rows 1.0,2.0,3.0,4.0 / 5.0,6.0,7.0,8.0 / 9.0…16.0, continuous valid. Expected outputs, in order: 6.0, 8.0, 14.0, 16.0, one cycle after inputs 6, 8, 14, 16. `frame_done` is set only with 16.0.
- **Input gaps.** Same plane with random 0–3 cycle gaps in `valid_in`. Expected: identical output values and order. Each `valid_out` occurs exactly 1 cycle after its window's last valid input.
- **Negatives and signed zero.**
  - Window {−3.0, −1.0, −2.0, −5.0} → −1.0.
  - Window {−0.0, +0.0, −0.0, −0.0} → −0.0 (bits 0x80000000, tie keeps the first operand).
  - Window {−1.0, 0.5, −2.0, 0.25} → 0.5.
- **Back-to-back planes.** Two consecutive 4×4 planes with no idle cycle. Expected: 8 outputs, and `frame_done` pulses twice. Second-plane values are unaffected by first-plane `linebuf` contents.
- **Reset mid-plane.** Assert `rst`=0 after 6 pixels of plane 1, then release and send a full 4×4 plane. Expected:
  - `o_data`, `valid_out` and `frame_done` read 0 during reset.
  - The post-reset plane yields exactly 4 correct outputs.
- **Full size.** 224×224 random non-negative FP32, checked against a reference model. Expected: 12544 outputs, all bit-exact, with exactly one `frame_done` pulse.

Source files
------------

// File: rtl/maxpool2x2_stream_pkg.sv
// Shared FP32 field layout and sizing helpers for the 2x2 max-pooling stream stage.
package maxpool2x2_stream_pkg;

  localparam int FP_SIGN_BIT = 31;
  localparam int FP_EXP_MSB  = 30;
  localparam int FP_EXP_LSB  = 23;
  localparam int FP_MAN_MSB  = 22;
  localparam int FP_MAN_LSB  = 0;
  localparam int FP_W        = FP_SIGN_BIT + 1;

  typedef struct packed {
    logic                             sign;
    logic [FP_EXP_MSB-FP_EXP_LSB:0]   exp;
    logic [FP_MAN_MSB-FP_MAN_LSB:0]   man;
  } fp32_t;

  // Line-buffer address width; a single-entry buffer still needs one address bit.
  function automatic int lb_aw(input int img_width);
    return (img_width / 2 > 1) ? $clog2(img_width / 2) : 1;
  endfunction

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/maxpool2x2_stream_if.sv
// Pixel stream in / pooled stream out bundle for maxpool2x2_stream.
interface maxpool2x2_stream_if
  import maxpool2x2_stream_pkg::*;
#(
  parameter int DATA_WIDTH = FP_W
);
  logic [DATA_WIDTH-1:0] i_data;
  logic                  valid_in;
  logic [DATA_WIDTH-1:0] o_data;
  logic                  valid_out;
  logic                  frame_done;

  modport master (
    output i_data, valid_in,
    input  o_data, valid_out, frame_done
  );

  modport slave (
    input  i_data, valid_in,
    output o_data, valid_out, frame_done
  );
endinterface

// File: rtl/maxpool2x2_stream_fp_max.sv
// Combinational sign-magnitude maximum of two FP32 values; ties (including -0 vs +0) return a.
module maxpool2x2_stream_fp_max
  import maxpool2x2_stream_pkg::*;
(
  input  fp32_t a,
  input  fp32_t b,
  output fp32_t y
);

  logic [FP_EXP_MSB-FP_MAN_LSB:0] mag_a;
  logic [FP_EXP_MSB-FP_MAN_LSB:0] mag_b;
  logic                           b_wins;

  assign mag_a = {a.exp, a.man};
  assign mag_b = {b.exp, b.man};

  always_comb begin
    b_wins = 1'b0;
    if (mag_a == '0 && mag_b == '0) begin
      b_wins = 1'b0;
    end else if (a.sign != b.sign) begin
      b_wins = a.sign;
    end else if (!a.sign) begin
      b_wins = (mag_b > mag_a);
    end else begin
      b_wins = (mag_b < mag_a);
    end
    y = b_wins ? b : a;
  end

endmodule

// File: rtl/maxpool2x2_stream.sv
// Streaming 2x2 stride-2 FP32 max-pool; a half-width line buffer keeps the upper-row pair maxima.
module maxpool2x2_stream
  import maxpool2x2_stream_pkg::*;
#(
  parameter int DATA_WIDTH = FP_W,
  parameter int IMG_WIDTH  = 224,
  parameter int IMG_HEIGHT = 224
)(
  input  logic                  clk,
  input  logic                  rst,
  maxpool2x2_stream_if.slave    strm
);

  localparam int COL_W  = cnt_w(IMG_WIDTH);
  localparam int ROW_W  = cnt_w(IMG_HEIGHT);
  localparam int LB_AW  = lb_aw(IMG_WIDTH);
  localparam int LB_DEP = IMG_WIDTH / 2;

  logic [COL_W-1:0]      col_q, col_d;
  logic [ROW_W-1:0]      row_q, row_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic [DATA_WIDTH-1:0] o_data_q, o_data_d;
  logic                  valid_out_q, valid_out_d;
  logic                  frame_done_q, frame_done_d;

  logic [DATA_WIDTH-1:0] lb_mem [LB_DEP];
  logic [LB_AW-1:0]      lb_addr;
  logic [DATA_WIDTH-1:0] lb_rd;
  logic                  lb_we;

  logic [DATA_WIDTH-1:0] pair_max;
  logic [DATA_WIDTH-1:0] win_max;
  logic                  col_last;
  logic                  row_last;

  assign col_last = (col_q == COL_W'(IMG_WIDTH - 1));
  assign row_last = (row_q == ROW_W'(IMG_HEIGHT - 1));
  assign lb_addr  = LB_AW'(col_q >> 1);
  assign lb_rd    = lb_mem[lb_addr];

  maxpool2x2_stream_fp_max u_fp_max_pair (
    .a (hold_q),
    .b (strm.i_data),
    .y (pair_max)
  );

  maxpool2x2_stream_fp_max u_fp_max_win (
    .a (pair_max),
    .b (lb_rd),
    .y (win_max)
  );

  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    hold_d       = hold_q;
    o_data_d     = o_data_q;
    valid_out_d  = 1'b0;
    frame_done_d = 1'b0;
    lb_we        = 1'b0;
    if (strm.valid_in) begin
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
      // Even column opens a pair; odd column closes it into the line buffer or the output.
      if (!col_q[0]) begin
        hold_d = strm.i_data;
      end else if (!row_q[0]) begin
        lb_we = 1'b1;
      end else begin
        o_data_d     = win_max;
        valid_out_d  = 1'b1;
        frame_done_d = row_last && col_last;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_q        <= '0;
      row_q        <= '0;
      hold_q       <= '0;
      o_data_q     <= '0;
      valid_out_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      hold_q       <= hold_d;
      o_data_q     <= o_data_d;
      valid_out_q  <= valid_out_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Not reset: row 0 of every plane rewrites each entry before any odd row reads it.
  always_ff @(posedge clk) begin
    if (lb_we) begin
      lb_mem[lb_addr] <= pair_max;
    end
  end

  assign strm.o_data     = o_data_q;
  assign strm.valid_out  = valid_out_q;
  assign strm.frame_done = frame_done_q;

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// Directed bench for maxpool2x2_stream: a 4x4 instance for hand-computed planes, a 224x224 instance for the full-size run.
module tb_maxpool2x2_stream;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  maxpool2x2_stream_if #(.DATA_WIDTH(32)) sif ();
  maxpool2x2_stream_if #(.DATA_WIDTH(32)) bif ();

  maxpool2x2_stream #(.DATA_WIDTH(32), .IMG_WIDTH(4), .IMG_HEIGHT(4)) u_small (
    .clk  (clk),
    .rst  (rst),
    .strm (sif)
  );

  maxpool2x2_stream #(.DATA_WIDTH(32), .IMG_WIDTH(224), .IMG_HEIGHT(224)) u_big (
    .clk  (clk),
    .rst  (rst),
    .strm (bif)
  );

  logic [31:0] p_inc [16];
  logic [31:0] e_inc [4];
  logic [31:0] p_neg [16];
  logic [31:0] e_neg [4];
  logic [31:0] btop  [112];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step_small(input logic [31:0] d, input logic vld);
    sif.i_data   = d;
    sif.valid_in = vld;
    @(posedge clk);
    #1;
    sif.valid_in = 1'b0;
  endtask

  // Feeds npix pixels of a 4x4 plane with 0..maxgap idle cycles before each one,
  // checking every output one cycle after the pixel that closes its window.
  task automatic send_plane4(input logic [31:0] px [16], input logic [31:0] ev [4],
                             input int maxgap, input int npix, input string tag);
    int n;
    int g;
    int r;
    int c;
    n = 0;
    for (int i = 0; i < npix; i++) begin
      g = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
      for (int k = 0; k < g; k++) begin
        step_small(32'h0, 1'b0);
        chk({tag, "_gap_vld"}, 32'(sif.valid_out), 32'd0);
      end
      step_small(px[i], 1'b1);
      r = i / 4;
      c = i % 4;
      if ((r % 2 == 1) && (c % 2 == 1)) begin
        chk({tag, "_vld"}, 32'(sif.valid_out), 32'd1);
        chk({tag, "_data"}, sif.o_data, ev[n]);
        chk({tag, "_done"}, 32'(sif.frame_done), 32'(i == 15));
        n++;
      end else begin
        chk({tag, "_idle_vld"}, 32'(sif.valid_out), 32'd0);
        chk({tag, "_idle_done"}, 32'(sif.frame_done), 32'd0);
      end
    end
  endtask

  initial begin
    logic [31:0] d;
    logic [31:0] bh;
    logic [31:0] pm;
    logic [31:0] ex;
    int          bout;
    int          bdone;

    p_inc = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
              32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000,
              32'h41100000, 32'h41200000, 32'h41300000, 32'h41400000,
              32'h41500000, 32'h41600000, 32'h41700000, 32'h41800000};
    e_inc = '{32'h40C00000, 32'h41000000, 32'h41600000, 32'h41800000};
    // Windows: {-3,-1,-2,-5} {-0,+0,-0,-0} {-1,0.5,-2,0.25} {1,2,3,4}
    p_neg = '{32'hC0400000, 32'hBF800000, 32'h80000000, 32'h00000000,
              32'hC0000000, 32'hC0A00000, 32'h80000000, 32'h80000000,
              32'hBF800000, 32'h3F000000, 32'h3F800000, 32'h40000000,
              32'hC0000000, 32'h3E800000, 32'h40400000, 32'h40800000};
    e_neg = '{32'hBF800000, 32'h80000000, 32'h3F000000, 32'h40800000};

    sif.i_data = '0; sif.valid_in = 1'b0;
    bif.i_data = '0; bif.valid_in = 1'b0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_o_data",     sif.o_data, 32'd0);
    chk("rst_valid_out",  32'(sif.valid_out), 32'd0);
    chk("rst_frame_done", 32'(sif.frame_done), 32'd0);
    chk("rst_big_o_data", bif.o_data, 32'd0);
    chk("rst_big_valid",  32'(bif.valid_out), 32'd0);
    rst = 1'b1;

    send_plane4(p_inc, e_inc, 0, 16, "basic");
    send_plane4(p_inc, e_inc, 3, 16, "gaps");
    send_plane4(p_neg, e_neg, 0, 16, "neg");
    send_plane4(p_inc, e_inc, 0, 16, "b2b_p1");
    send_plane4(p_neg, e_neg, 0, 16, "b2b_p2");

    // Six pixels leave an output pending on the wire, then reset lands mid-plane.
    send_plane4(p_inc, e_inc, 0, 6, "pre_rst");
    rst = 1'b0;
    #2;
    chk("midrst_o_data",     sif.o_data, 32'd0);
    chk("midrst_valid_out",  32'(sif.valid_out), 32'd0);
    chk("midrst_frame_done", 32'(sif.frame_done), 32'd0);
    @(posedge clk);
    #1;
    chk("midrst_hold_valid", 32'(sif.valid_out), 32'd0);
    rst = 1'b1;
    send_plane4(p_inc, e_inc, 2, 16, "post_rst");

    bout  = 0;
    bdone = 0;
    bh    = '0;
    for (int r = 0; r < 224; r++) begin
      for (int c = 0; c < 224; c++) begin
        d = {1'b0, 8'($urandom_range(0, 254)), 23'($urandom)};
        bif.i_data   = d;
        bif.valid_in = 1'b1;
        @(posedge clk);
        #1;
        bif.valid_in = 1'b0;
        chk("big_vld", 32'(bif.valid_out), 32'((r % 2 == 1) && (c % 2 == 1)));
        if (bif.valid_out) bout++;
        if (bif.frame_done) bdone++;
        if (c % 2 == 0) begin
          bh = d;
        end else begin
          pm = (d > bh) ? d : bh;
          if (r % 2 == 0) begin
            btop[c / 2] = pm;
          end else begin
            ex = (btop[c / 2] > pm) ? btop[c / 2] : pm;
            chk("big_data", bif.o_data, ex);
          end
        end
      end
    end
    chk("big_out_count", 32'(bout), 32'd12544);
    chk("big_done_count", 32'(bdone), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
